// File: rtl/uart_apb_regif_pkg.sv
// Shared register map, bit indices and APB FSM encoding for the UART register interface.
package uart_apb_regif_pkg;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_BAUD     = 3'd1;
  localparam logic [2:0] OFF_STATUS   = 3'd2;
  localparam logic [2:0] OFF_TXDATA   = 3'd3;
  localparam logic [2:0] OFF_RXDATA   = 3'd4;
  localparam logic [2:0] OFF_IRQ_EN   = 3'd5;
  localparam logic [2:0] OFF_IRQ_STAT = 3'd6;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_PAR_EN  = 1;
  localparam int CTRL_PAR_ODD = 2;
  localparam int CTRL_STOP2   = 3;
  localparam int CTRL_W       = 4;

  localparam int IRQ_TX   = 0;
  localparam int IRQ_RX   = 1;
  localparam int IRQ_OVR  = 2;
  localparam int IRQ_FERR = 3;
  localparam int N_IRQ    = 4;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

  // Direction-dependent decode errors for an aligned, in-range offset.
  function automatic logic off_err(input logic [2:0] off, input logic wr);
    case (off)
      OFF_STATUS, OFF_RXDATA: off_err = wr;
      OFF_TXDATA:             off_err = !wr;
      3'd7:                   off_err = 1'b1;
      default:                off_err = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_apb_regif_if.sv
// APB bus bundle between the host bridge and the UART register interface.
interface uart_apb_regif_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PERROR;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  input  PRDATA, PREADY, PERROR);
  modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
                  output PRDATA, PREADY, PERROR);
endinterface

// File: rtl/uart_apb_regif_irq.sv
// Interrupt status: edge detect on core ready/valid, sticky W1C status, registered irq.
module uart_regif_irq
  import uart_apb_regif_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_ready,
  input  logic             rx_valid,
  input  logic             rx_overrun,
  input  logic             rx_frame_err,
  input  logic             w1c_en,
  input  logic [N_IRQ-1:0] w1c_mask,
  input  logic [N_IRQ-1:0] irq_en,
  output logic [N_IRQ-1:0] irq_stat,
  output logic             irq
);

  logic             tx_ready_q, tx_ready_d;
  logic             rx_valid_q, rx_valid_d;
  logic [N_IRQ-1:0] stat_q, stat_d;
  logic             irq_q, irq_d;
  logic [N_IRQ-1:0] ev;

  always_comb begin
    ev           = '0;
    ev[IRQ_TX]   = tx_ready & ~tx_ready_q;
    ev[IRQ_RX]   = rx_valid & ~rx_valid_q;
    ev[IRQ_OVR]  = rx_overrun;
    ev[IRQ_FERR] = rx_frame_err;
    stat_d       = stat_q;
    if (w1c_en) stat_d = stat_d & ~w1c_mask;
    // New events are ORed in after the clear so a coincident set wins.
    stat_d       = stat_d | ev;
    irq_d        = |(stat_q & irq_en);
    tx_ready_d   = tx_ready;
    rx_valid_d   = rx_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      stat_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      stat_q     <= stat_d;
      irq_q      <= irq_d;
    end
  end

  assign irq_stat = stat_q;
  assign irq      = irq_q;

endmodule

// File: rtl/uart_apb_regif.sv
// APB slave register interface for the UART: decode, wait states with timeout,
// register bank and TX/RX byte handshakes to the core.
module uart_apb_regif
  import uart_apb_regif_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int BAUD_W   = 16,
  parameter int BAUD_RST = 27,
  parameter int TIMEOUT  = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  uart_apb_regif_if.slave   apb,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              rx_overrun,
  input  logic              rx_frame_err,
  output logic              uart_en,
  output logic              parity_en,
  output logic              parity_odd,
  output logic              stop2,
  output logic [BAUD_W-1:0] baud_div,
  output logic              irq
);

  localparam int CNT_W = $clog2(TIMEOUT + 2);

  apb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [N_IRQ-1:0]  irq_en_q, irq_en_d;
  logic [N_IRQ-1:0]  irq_stat;

  logic [2:0]        off;
  logic              dec_err, acc, is_tx, is_rx, timeout, core_rdy, done, wr_ok, w1c_en;
  logic [DATA_W-1:0] rdata;
  logic              unused_pwdata;

  assign off           = apb.PADDR[4:2];
  assign unused_pwdata = ^apb.PWDATA;

  always_comb begin
    dec_err  = (apb.PADDR[1:0] != 2'b00) || ((apb.PADDR >> 5) != '0) || off_err(off, apb.PWRITE);
    // A reset cycle never counts as an access, so no push/pop can leak out of it.
    acc      = PRESETn && apb.PSEL && apb.PENABLE && (state_q != IDLE);
    is_tx    = !dec_err && apb.PWRITE && (off == OFF_TXDATA);
    is_rx    = !dec_err && !apb.PWRITE && (off == OFF_RXDATA);
    timeout  = (TIMEOUT != 0) && (wait_cnt_q == CNT_W'(TIMEOUT));
    core_rdy = is_tx ? tx_ready : (is_rx ? rx_valid : 1'b1);
    done     = dec_err || timeout || core_rdy;
    wr_ok    = acc && apb.PWRITE && !dec_err;
    w1c_en   = wr_ok && (off == OFF_IRQ_STAT);
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL:     rdata[CTRL_W-1:0] = ctrl_q;
      OFF_BAUD:     rdata[BAUD_W-1:0] = baud_q;
      OFF_STATUS:   rdata[3:0]        = {irq_stat[IRQ_FERR], irq_stat[IRQ_OVR], rx_valid, tx_ready};
      OFF_RXDATA:   rdata[7:0]        = rx_data;
      OFF_IRQ_EN:   rdata[N_IRQ-1:0]  = irq_en_q;
      OFF_IRQ_STAT: rdata[N_IRQ-1:0]  = irq_stat;
      default:      rdata             = '0;
    endcase
  end

  always_comb begin
    apb.PREADY = !acc || done;
    apb.PERROR = acc && (dec_err || timeout);
    apb.PRDATA = (acc && !apb.PWRITE && !dec_err && !timeout && core_rdy) ? rdata : '0;
    tx_data    = apb.PWDATA[7:0];
    tx_valid   = acc && is_tx && !timeout;
    rx_ready   = acc && is_rx && rx_valid && !timeout;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (apb.PSEL && !apb.PENABLE) state_d = SETUP;
      SETUP, ACCESS: begin
        if (!apb.PSEL)         state_d = IDLE;
        else if (!apb.PENABLE) state_d = SETUP;
        else if (done)         state_d = IDLE;
        else                   state_d = ACCESS;
      end
      default: state_d = IDLE;
    endcase
    wait_cnt_d = (acc && !done) ? wait_cnt_q + CNT_W'(1) : '0;
  end

  // Only TXDATA/RXDATA wait; every writable register completes on its first access cycle.
  always_comb begin
    ctrl_d   = ctrl_q;
    baud_d   = baud_q;
    irq_en_d = irq_en_q;
    if (wr_ok) begin
      case (off)
        OFF_CTRL:   ctrl_d   = apb.PWDATA[CTRL_W-1:0];
        OFF_BAUD:   baud_d   = apb.PWDATA[BAUD_W-1:0];
        OFF_IRQ_EN: irq_en_d = apb.PWDATA[N_IRQ-1:0];
        default:    ;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      ctrl_q     <= '0;
      baud_q     <= BAUD_W'(BAUD_RST);
      irq_en_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ctrl_q     <= ctrl_d;
      baud_q     <= baud_d;
      irq_en_q   <= irq_en_d;
    end
  end

  uart_regif_irq u_irq (
    .clk          (PCLK),
    .rst_n        (PRESETn),
    .tx_ready     (tx_ready),
    .rx_valid     (rx_valid),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err),
    .w1c_en       (w1c_en),
    .w1c_mask     (apb.PWDATA[N_IRQ-1:0]),
    .irq_en       (irq_en_q),
    .irq_stat     (irq_stat),
    .irq          (irq)
  );

  assign uart_en    = ctrl_q[CTRL_EN];
  assign parity_en  = ctrl_q[CTRL_PAR_EN];
  assign parity_odd = ctrl_q[CTRL_PAR_ODD];
  assign stop2      = ctrl_q[CTRL_STOP2];
  assign baud_div   = baud_q;

endmodule
